// File: rtl/sr_latch_drive_ctrl.sv
// Drive controller for a gated SR latch: sequences each write as setup -> enable pulse -> hold,
// then checks the latch q feedback against the expected state. All outputs are registered.
module sr_latch_drive_ctrl #(
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   output logic       req_ready,
   output logic       s,
   output logic       r,
   output logic       e,
   input  logic       q_in,
   output logic       q_exp,
   output logic       done,
   output logic       err
);

   localparam int SetupEff = (SETUP_CYC < 1) ? 1 : SETUP_CYC;
   localparam int PulseEff = (PULSE_CYC < 1) ? 1 : PULSE_CYC;
   localparam int HoldEff  = (HOLD_CYC  < 1) ? 1 : HOLD_CYC;
   localparam int MaxSP    = (SetupEff > PulseEff) ? SetupEff : PulseEff;
   localparam int MaxCyc   = (MaxSP > HoldEff) ? MaxSP : HoldEff;
   localparam int CntW     = $clog2(MaxCyc + 1);

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ENABLE,
      HOLD,
      CHECK
   } state_t;

   state_t            state;
   logic [CntW-1:0]   cnt;
   logic              target;
   logic              nextTarget;
   logic              accept;

   // req_ready is registered and only ever high in IDLE, so it doubles as the idle flag.
   assign accept = req_valid & req_ready;

   always_comb begin
      nextTarget = 1'b0;
      case (op_t'(req_op))
         OP_SET:    nextTarget = 1'b1;
         OP_TOGGLE: nextTarget = ~q_exp;
         default:   nextTarget = 1'b0;
      endcase
   end

   // NOTE: all state and outputs use non-blocking assignments so every register
   // samples pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         target    <= 1'b0;
         s         <= 1'b0;
         r         <= 1'b0;
         e         <= 1'b0;
         q_exp     <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (op_t'(req_op) == OP_NOP) begin
                     done <= 1'b1;
                  end else begin
                     target    <= nextTarget;
                     s         <= nextTarget;
                     r         <= ~nextTarget;
                     cnt       <= CntW'(SetupEff - 1);
                     req_ready <= 1'b0;
                     state     <= SETUP;
                  end
               end
            end
            SETUP: begin
               if (cnt == '0) begin
                  e     <= 1'b1;
                  cnt   <= CntW'(PulseEff - 1);
                  state <= ENABLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ENABLE: begin
               if (cnt == '0) begin
                  e     <= 1'b0;
                  cnt   <= CntW'(HoldEff - 1);
                  state <= HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  s     <= 1'b0;
                  r     <= 1'b0;
                  state <= CHECK;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CHECK: begin
               // An unknown q_in compares as a mismatch.
               q_exp     <= target;
               err       <= err | (q_in !== target);
               done      <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               s         <= 1'b0;
               r         <= 1'b0;
               e         <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
